// File: rtl/seq_detect_sched.sv
// rtl/seq_detect_sched.sv - round-robin job scheduler sharing one serial sequence detector
// Optional pre-job detector flush is compiled in with SEQ_SCHED_FLUSH_EN.
module seq_detect_sched #(
    parameter int NREQ   = 4,
    parameter int WORD_W = 16,
    parameter int LEN_W  = 5,
    parameter int CNT_W  = 5,
    localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ*WORD_W-1:0]  data_i,
    input  logic [NREQ*LEN_W-1:0]   len_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic                    busy_o,
    output logic                    det_in,
    output logic                    det_rst_n,
    input  logic                    det_out,
    output logic                    done_o,
    output logic [ID_W-1:0]         done_id_o,
    output logic [CNT_W-1:0]        match_cnt_o
);

    localparam logic [2:0] IDLE  = 3'd0;
`ifdef SEQ_SCHED_FLUSH_EN
    localparam logic [2:0] FLUSH = 3'd1;
`endif
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WORD_W-1:0] word_q, word_d;
`ifdef SEQ_SCHED_FLUSH_EN
    logic [LEN_W-1:0]  len_q, len_d;
`endif
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic              first_q, first_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              busy_q, busy_d;
    logic              det_in_q, det_in_d;
    logic              det_rst_n_q, det_rst_n_d;
    logic              done_q, done_d;
    logic [ID_W-1:0]   done_id_q, done_id_d;
    logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;

    logic              pick_valid;
    logic [ID_W-1:0]   pick_id, cand;
    logic [WORD_W-1:0] sel_word, shifted;
    logic [LEN_W-1:0]  sel_len_raw, sel_len;
    logic [CNT_W-1:0]  cnt_inc;

    // Descending scan so the lowest offset from rr_ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = ID_W'((int'(rr_ptr_q) + i) % NREQ);
            if (req_i[cand]) begin
                pick_valid = 1'b1;
                pick_id    = cand;
            end
        end
        sel_word    = data_i[int'(pick_id)*WORD_W +: WORD_W];
        sel_len_raw = len_i[int'(pick_id)*LEN_W +: LEN_W];
        sel_len     = (sel_len_raw > LEN_W'(WORD_W)) ? LEN_W'(WORD_W) : sel_len_raw;
        cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        word_d      = word_q;
`ifdef SEQ_SCHED_FLUSH_EN
        len_d       = len_q;
`endif
        idx_d       = idx_q;
        first_d     = 1'b0;
        cnt_d       = cnt_q;
        id_d        = id_q;
        gnt_d       = '0;
        busy_d      = busy_q;
        det_in_d    = 1'b0;
        det_rst_n_d = 1'b1;
        done_d      = 1'b0;
        done_id_d   = done_id_q;
        match_cnt_d = match_cnt_q;
        shifted     = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d[pick_id] = 1'b1;
                    busy_d         = 1'b1;
                    word_d         = sel_word;
                    id_d           = pick_id;
                    cnt_d          = '0;
                    rr_ptr_d       = (int'(pick_id) == NREQ - 1) ? '0 : pick_id + 1'b1;
`ifdef SEQ_SCHED_FLUSH_EN
                    len_d       = sel_len;
                    det_rst_n_d = 1'b0;
                    state_d     = FLUSH;
`else
                    if (sel_len == '0) begin
                        state_d = DONE;
                    end else begin
                        shifted  = sel_word >> (sel_len - 1'b1);
                        det_in_d = shifted[0];
                        idx_d    = sel_len - 1'b1;
                        first_d  = 1'b1;
                        state_d  = SHIFT;
                    end
`endif
                end
            end
`ifdef SEQ_SCHED_FLUSH_EN
            FLUSH: begin
                if (len_q == '0) begin
                    state_d = DONE;
                end else begin
                    shifted  = word_q >> (len_q - 1'b1);
                    det_in_d = shifted[0];
                    idx_d    = len_q - 1'b1;
                    first_d  = 1'b1;
                    state_d  = SHIFT;
                end
            end
`endif
            SHIFT: begin
                // The first SHIFT cycle still sees the detector's pre-job output.
                if (!first_q && det_out) cnt_d = cnt_inc;
                if (idx_q == '0) begin
                    state_d = DRAIN;
                end else begin
                    shifted  = word_q >> (idx_q - 1'b1);
                    det_in_d = shifted[0];
                    idx_d    = idx_q - 1'b1;
                end
            end
            DRAIN: begin
                if (det_out) cnt_d = cnt_inc;
                state_d = DONE;
            end
            DONE: begin
                done_d      = 1'b1;
                done_id_d   = id_q;
                match_cnt_d = cnt_q;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            word_q      <= '0;
`ifdef SEQ_SCHED_FLUSH_EN
            len_q       <= '0;
`endif
            idx_q       <= '0;
            first_q     <= 1'b0;
            cnt_q       <= '0;
            id_q        <= '0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            det_in_q    <= 1'b0;
            det_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            word_q      <= word_d;
`ifdef SEQ_SCHED_FLUSH_EN
            len_q       <= len_d;
`endif
            idx_q       <= idx_d;
            first_q     <= first_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            det_in_q    <= det_in_d;
            det_rst_n_q <= det_rst_n_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign busy_o      = busy_q;
    assign det_in      = det_in_q;
    assign det_rst_n   = det_rst_n_q;
    assign done_o      = done_q;
    assign done_id_o   = done_id_q;
    assign match_cnt_o = match_cnt_q;

endmodule

// File: tb/tb_seq_detect_sched.sv
// tb/tb_seq_detect_sched.sv - randomized bench for seq_detect_sched with a "1011" detector model
module tb_seq_detect_sched;

    localparam int NREQ = 4;
`ifdef SEQ_SCHED_FLUSH_EN
    localparam int FL = 1;
`else
    localparam int FL = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_i = '0;
    logic [63:0] data_i = '0;
    logic [19:0] len_i = '0;
    logic [3:0]  gnt_o;
    logic        busy_o, det_in, det_rst_n, det_out, done_o;
    logic [1:0]  done_id_o;
    logic [4:0]  match_cnt_o;
    logic [3:0]  det_sr;

    int checks = 0;
    int errors = 0;
    int ptr = 0;

    always #5 clk = ~clk;

    seq_detect_sched dut (
        .clk(clk), .rst(rst), .req_i(req_i), .data_i(data_i), .len_i(len_i),
        .gnt_o(gnt_o), .busy_o(busy_o), .det_in(det_in), .det_rst_n(det_rst_n),
        .det_out(det_out), .done_o(done_o), .done_id_o(done_id_o), .match_cnt_o(match_cnt_o)
    );

    // Overlapping "1011" detector, output one cycle after the final bit.
    always @(posedge clk or negedge det_rst_n) begin
        if (!det_rst_n) begin
            det_sr  <= '0;
            det_out <= 1'b0;
        end else begin
            det_sr  <= {det_sr[2:0], det_in};
            det_out <= ({det_sr[2:0], det_in} == 4'b1011);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_job(input logic [3:0] req, input logic [63:0] data,
                           input logic [19:0] len, input bit hold);
        int id, L, cnt, lat, exp_bit;
        int b[16];
        logic [15:0] w;
        logic [4:0]  lk;
        req_i  = req;
        data_i = data;
        len_i  = len;
        id = -1;
        for (int i = NREQ - 1; i >= 0; i--)
            if (req[(ptr + i) % NREQ]) id = (ptr + i) % NREQ;
        @(posedge clk); #1;
        if (id < 0) begin
            check_eq("idle_gnt", 32'(gnt_o), 32'd0);
            check_eq("idle_busy", 32'(busy_o), 32'd0);
            return;
        end
        ptr = (id + 1) % NREQ;
        w  = data[id*16 +: 16];
        lk = len[id*5 +: 5];
        L  = (lk > 5'd16) ? 16 : int'(lk);
        for (int j = 0; j < 16; j++) b[j] = (j < L) ? int'(w[L-1-j]) : 0;
        cnt = 0;
        for (int j = 3; j < L; j++)
            if (b[j-3] == 1 && b[j-2] == 0 && b[j-1] == 1 && b[j] == 1) cnt++;
        if (cnt > 31) cnt = 31;
        lat = (L == 0) ? 1 + FL : L + 2 + FL;
        for (int c = 0; c <= lat; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            exp_bit = (c >= FL && c < FL + L) ? b[c-FL] : 0;
            check_eq("gnt", 32'(gnt_o), (c == 0) ? (32'd1 << id) : 32'd0);
            check_eq("busy", 32'(busy_o), 32'(c < lat));
            check_eq("det_in", 32'(det_in), 32'(exp_bit));
            check_eq("det_rst_n", 32'(det_rst_n), 32'(!(FL == 1 && c == 0)));
            check_eq("done", 32'(done_o), 32'(c == lat));
            if (c == lat) begin
                check_eq("done_id", 32'(done_id_o), 32'(id));
                check_eq("match_cnt", 32'(match_cnt_o), 32'(cnt));
            end
            if (!hold && c < lat) begin
                req_i  = 4'($urandom);
                data_i = {$urandom, $urandom};
                len_i  = 20'($urandom);
            end
        end
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outs", {gnt_o, busy_o, det_in, det_rst_n, done_o, done_id_o, match_cnt_o}, 32'd0);
        @(negedge clk) rst = 1'b1;
        #1 check_eq("det_rst_n_pre", 32'(det_rst_n), 32'd0);
        @(posedge clk); #1;
        check_eq("det_rst_n_rel", 32'(det_rst_n), 32'd1);
        check_eq("busy_rel", 32'(busy_o), 32'd0);

        run_job(4'b0001, {4{16'h05B6}}, {4{5'd11}}, 1'b1);

        for (int k = 0; k < 4; k++)
            run_job(4'b0101, {$urandom, $urandom}, {4{5'(8 + k)}}, 1'b1);

        run_job(4'b0010, {$urandom, $urandom}, {4{5'd0}}, 1'b0);
        run_job(4'b0100, {$urandom, $urandom}, {4{5'd20}}, 1'b0);

        run_job(4'b0001, {48'h0, 16'h0005}, {15'h0, 5'd3}, 1'b1);
        run_job(4'b0010, {32'h0, 16'h0001, 16'h0}, {10'h0, 5'd1, 5'd0}, 1'b1);

        for (int k = 0; k < 30; k++)
            run_job(4'($urandom), {$urandom, $urandom}, 20'($urandom), 1'b0);

        req_i  = 4'b0001;
        data_i = {$urandom, $urandom};
        len_i  = {4{5'd16}};
        ptr    = 1;
        @(posedge clk); #1;
        check_eq("abort_gnt", 32'(gnt_o), 32'd1);
        repeat (4 + FL) @(posedge clk);
        #2 rst = 1'b0;
        #1 check_eq("abort_outs", {gnt_o, busy_o, det_in, det_rst_n, done_o, done_id_o, match_cnt_o}, 32'd0);
        req_i = '0;
        repeat (2) begin
            @(posedge clk); #1;
            check_eq("abort_done", 32'(done_o), 32'd0);
        end
        @(negedge clk) rst = 1'b1;
        ptr = 0;
        @(posedge clk); #1;
        check_eq("abort_det_rst_n", 32'(det_rst_n), 32'd1);
        run_job(4'b1001, {$urandom, $urandom}, 20'($urandom), 1'b0);
        run_job(4'b1000, {$urandom, $urandom}, 20'($urandom), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
